// File: rtl/arith_seq_unit.sv
// Signed add/sub/shift-add multiply with sequential double-dabble
// and a scanned 4-digit seven-segment readout.
module arith_seq_unit #(
    parameter int WIDTH   = 8,
    parameter int DIVIDER = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       mode,
    input  logic [2:0]       btn,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             rng,
    output logic             neg,
    output logic [6:0]       D1_SEG,
    output logic [3:0]       D1_AN
);

    localparam int RW  = 2 * WIDTH;
    localparam int CW  = $clog2(RW) + 1;
    localparam int SCW = $clog2(DIVIDER) + 1;
    localparam int MW  = (RW > 10) ? RW : 10;
    localparam logic [6:0] DASH  = 7'b011_1111;
    localparam logic [6:0] BLANK = 7'b111_1111;

    typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

    state_t state, state_nx;

    logic [2:0]       btn_q, rise;
    logic [WIDTH-1:0] op1, op2, opa, opb, mplier;
    logic [1:0]       mode_q;
    logic [RW-1:0]    mcand, acc, res, bin;
    logic             sgn, calc_ovf;
    logic [15:0]      bcd;
    logic [CW-1:0]    cnt;
    logic [3:0]       dig0, dig1, dig2;
    logic             neg_d, ovf_d, rng_d;
    logic [SCW-1:0]   scan;

    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (WIDTH'(0) - x) : x;
    endfunction

    function automatic logic [3:0] adj3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd1:    s = 7'b111_1001;
            4'd2:    s = 7'b010_0100;
            4'd3:    s = 7'b011_0000;
            4'd4:    s = 7'b001_1001;
            4'd5:    s = 7'b001_0010;
            4'd6:    s = 7'b000_0010;
            4'd7:    s = 7'b111_1000;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b001_0000;
            default: s = 7'b100_0000;
        endcase
        return s;
    endfunction

    assign rise = btn & ~btn_q;
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign ovf  = ovf_d;
    assign rng  = rng_d;
    assign neg  = neg_d;

    logic             is_mul, is_sub, cin, c_in_msb, c_out_msb;
    logic [WIDTH-1:0] b_eff, lo_sum;
    logic [RW-1:0]    a_x, b_x, as_res, acc_nx, mul_res, res_nx, mag_nx, res_mag;
    logic [MW-1:0]    mag_ext;
    logic [15:0]      bcd_adj;
    logic             calc_last, conv_last;

    assign is_mul = (mode_q == 2'b10);
    assign is_sub = (mode_q == 2'b01);

    // Carries at WIDTH bits give the add/sub overflow flag
    assign cin       = is_sub;
    assign b_eff     = is_sub ? ~opb : opb;
    assign lo_sum    = {1'b0, opa[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                     + {{(WIDTH-1){1'b0}}, cin};
    assign c_in_msb  = lo_sum[WIDTH-1];
    assign c_out_msb = (opa[WIDTH-1] & b_eff[WIDTH-1])
                     | (opa[WIDTH-1] & c_in_msb)
                     | (b_eff[WIDTH-1] & c_in_msb);

    assign a_x     = {{WIDTH{opa[WIDTH-1]}}, opa};
    assign b_x     = {{WIDTH{opb[WIDTH-1]}}, opb};
    assign as_res  = is_sub ? (a_x - b_x) : (a_x + b_x);
    assign acc_nx  = acc + (mplier[0] ? mcand : RW'(0));
    assign mul_res = sgn ? (RW'(0) - acc_nx) : acc_nx;
    assign res_nx  = is_mul ? mul_res : as_res;
    assign mag_nx  = res_nx[RW-1] ? (RW'(0) - res_nx) : res_nx;
    assign res_mag = res[RW-1] ? (RW'(0) - res) : res;
    assign mag_ext = MW'(res_mag);

    assign bcd_adj = {adj3(bcd[15:12]), adj3(bcd[11:8]),
                      adj3(bcd[7:4]), adj3(bcd[3:0])};

    assign calc_last = !is_mul || (cnt == CW'(WIDTH - 1));
    assign conv_last = (cnt == CW'(RW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (rise[2]) state_nx = CALC;
            CALC:    if (calc_last) state_nx = CONV;
            CONV:    if (conv_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q    <= '0;
            op1      <= '0;
            op2      <= '0;
            opa      <= '0;
            opb      <= '0;
            mode_q   <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            sgn      <= 1'b0;
            res      <= '0;
            calc_ovf <= 1'b0;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            dig0     <= '0;
            dig1     <= '0;
            dig2     <= '0;
            neg_d    <= 1'b0;
            ovf_d    <= 1'b0;
            rng_d    <= 1'b0;
            scan     <= '0;
        end else begin
            btn_q <= btn;
            scan  <= scan + SCW'(1);
            unique case (state)
                IDLE: begin
                    if (rise[0]) op1 <= sw;
                    if (rise[1]) op2 <= sw;
                    // Working copies keep the pre-load operands
                    if (rise[2]) begin
                        mode_q <= mode;
                        opa    <= op1;
                        opb    <= op2;
                        mcand  <= {{WIDTH{1'b0}}, mag_w(op1)};
                        mplier <= mag_w(op2);
                        acc    <= '0;
                        sgn    <= op1[WIDTH-1] ^ op2[WIDTH-1];
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (is_mul) begin
                        acc    <= acc_nx;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                    if (calc_last) begin
                        res      <= res_nx;
                        calc_ovf <= is_mul ? 1'b0 : (c_in_msb ^ c_out_msb);
                        bin      <= mag_nx;
                        bcd      <= '0;
                        cnt      <= '0;
                    end
                end
                CONV: begin
                    bcd <= {bcd_adj[14:0], bin[RW-1]};
                    bin <= bin << 1;
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    dig0  <= bcd[3:0];
                    dig1  <= bcd[7:4];
                    dig2  <= bcd[11:8];
                    neg_d <= res[RW-1];
                    ovf_d <= calc_ovf;
                    rng_d <= (mag_ext > MW'(999));
                end
                default: ;
            endcase
        end
    end

    logic [1:0] sel;
    assign sel = scan[SCW-1 -: 2];

    always_comb begin
        D1_AN  = 4'b1111;
        D1_SEG = BLANK;
        unique case (sel)
            2'b00: begin
                D1_AN  = 4'b1110;
                D1_SEG = rng_d ? DASH : seg7(dig0);
            end
            2'b01: begin
                D1_AN  = 4'b1101;
                D1_SEG = rng_d ? DASH : seg7(dig1);
            end
            2'b10: begin
                D1_AN  = 4'b1011;
                D1_SEG = rng_d ? DASH : seg7(dig2);
            end
            default: begin
                D1_AN  = 4'b0111;
                D1_SEG = neg_d ? DASH : BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_arith_seq_unit.sv
// Randomised and directed checks of arith_seq_unit against an
// integer-arithmetic model of results, flags, latency and display.
module tb_arith_seq_unit;

    localparam int W   = 8;
    localparam int DIV = 4;
    localparam logic [6:0] DASH  = 7'b011_1111;
    localparam logic [6:0] BLANK = 7'b111_1111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic [1:0]   mode;
    logic [2:0]   btn;
    logic         busy, done, ovf, rng, neg;
    logic [6:0]   D1_SEG;
    logic [3:0]   D1_AN;

    int errors = 0;
    int checks = 0;
    int m_op1  = 0;
    int m_op2  = 0;

    arith_seq_unit #(.WIDTH(W), .DIVIDER(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode), .btn(btn),
        .busy(busy), .done(done), .ovf(ovf), .rng(rng), .neg(neg),
        .D1_SEG(D1_SEG), .D1_AN(D1_AN)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b100_0000;
            1: return 7'b111_1001;
            2: return 7'b010_0100;
            3: return 7'b011_0000;
            4: return 7'b001_1001;
            5: return 7'b001_0010;
            6: return 7'b000_0010;
            7: return 7'b111_1000;
            8: return 7'b000_0000;
            9: return 7'b001_0000;
            default: return 7'b100_0000;
        endcase
    endfunction

    function automatic int to_s(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic check_display(input string tag, input int mag,
                                 input bit rx, input bit nx);
        logic [6:0] exp;
        logic [3:0] seen;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp = 7'bx;
            case (D1_AN)
                4'b1110: begin
                    exp = rx ? DASH : seg_of(mag % 10);
                    seen[0] = 1'b1;
                end
                4'b1101: begin
                    exp = rx ? DASH : seg_of((mag / 10) % 10);
                    seen[1] = 1'b1;
                end
                4'b1011: begin
                    exp = rx ? DASH : seg_of((mag / 100) % 10);
                    seen[2] = 1'b1;
                end
                4'b0111: begin
                    exp = nx ? DASH : BLANK;
                    seen[3] = 1'b1;
                end
                default: ;
            endcase
            checks++;
            if (D1_SEG !== exp) begin
                errors++;
                $display("FAIL %s seg an=%b got=%b exp=%b",
                         tag, D1_AN, D1_SEG, exp);
            end
        end
        checks++;
        if (seen !== 4'b1111) begin
            errors++;
            $display("FAIL %s anodes seen=%b exp=1111", tag, seen);
        end
    endtask

    task automatic do_start(input string tag, input logic [1:0] m,
                            input logic [1:0] ld, input logic [W-1:0] v);
        int r, mag, lat, n;
        bit ox, nx, rx, got;
        case (m)
            2'b01:   r = m_op1 - m_op2;
            2'b10:   r = m_op1 * m_op2;
            default: r = m_op1 + m_op2;
        endcase
        ox  = (m != 2'b10) &&
              ((r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1))));
        nx  = (r < 0);
        mag = nx ? -r : r;
        rx  = (mag > 999);
        lat = (m == 2'b10) ? 1 + 3 * W : 2 + 2 * W;
        if (ld[0]) m_op1 = to_s(v);
        if (ld[1]) m_op2 = to_s(v);
        @(negedge clk);
        mode = m;
        sw   = v;
        btn  = {1'b1, ld};
        n    = 0;
        got  = 0;
        while (n < 200 && !got) begin
            @(negedge clk);
            if (n == 0) begin
                btn = '0;
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy got=%b exp=1", tag, busy);
                end
            end
            n++;
            if (done === 1'b1) got = 1;
        end
        checks++;
        if (!got || n != lat) begin
            errors++;
            $display("FAIL %s latency got=%0d exp=%0d", tag, n, lat);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle done=%b busy=%b exp=0,0",
                     tag, done, busy);
        end
        checks++;
        if ({ovf, neg, rng} !== {ox, nx, rx}) begin
            errors++;
            $display("FAIL %s flags ovf/neg/rng got=%b%b%b exp=%b%b%b",
                     tag, ovf, neg, rng, ox, nx, rx);
        end
        check_display(tag, mag, rx, nx);
    endtask

    task automatic load(input int a, input int b);
        @(negedge clk);
        sw  = W'(a);
        btn = 3'b001;
        @(negedge clk);
        btn = '0;
        sw  = W'(b);
        btn = 3'b010;
        @(negedge clk);
        btn = '0;
        m_op1 = to_s(W'(a));
        m_op2 = to_s(W'(b));
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sw    = 8'd33;
        btn   = 3'b001;
        mode  = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, ovf, rng, neg} !== 5'b0) begin
            errors++;
            $display("FAIL reset outs got=%b exp=00000",
                     {busy, done, ovf, rng, neg});
        end
        rst_n = 1'b1;
        @(negedge clk);
        btn   = '0;
        m_op1 = 33;
        m_op2 = 0;
        check_display("reset_disp", 0, 0, 0);
        do_start("held_btn_load", 2'b00, 2'b00, '0);
    endtask

    task automatic test_directed;
        load(100, 27);
        do_start("add_127", 2'b00, 2'b00, '0);
        load(100, 100);
        do_start("add_ovf", 2'b00, 2'b00, '0);
        load(5, 20);
        do_start("sub_neg", 2'b01, 2'b00, '0);
        load(-12, 11);
        do_start("mul_neg", 2'b10, 2'b00, '0);
        load(127, 127);
        do_start("mul_rng", 2'b10, 2'b00, '0);
        load(-128, -128);
        do_start("mul_min", 2'b10, 2'b00, '0);
        load(-128, 1);
        do_start("sub_min", 2'b01, 2'b00, '0);
        load(0, -77);
        do_start("mul_zero", 2'b10, 2'b00, '0);
        load(-100, -50);
        do_start("mode3_add", 2'b11, 2'b00, '0);
    endtask

    task automatic test_simul_load;
        load(9, 4);
        do_start("simul_old", 2'b01, 2'b01, 8'd50);
        do_start("simul_new", 2'b01, 2'b00, '0);
    endtask

    task automatic test_busy_load;
        int n;
        load(-12, 11);
        @(negedge clk);
        mode = 2'b10;
        btn  = 3'b100;
        @(negedge clk);
        btn  = '0;
        @(negedge clk);
        sw   = 8'd55;
        btn  = 3'b011;
        @(negedge clk);
        btn  = '0;
        n    = 0;
        while (n < 100 && done !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL busy_load done_wait got=%b exp=1", done);
        end
        repeat (2) @(negedge clk);
        do_start("busy_load", 2'b00, 2'b00, '0);
    endtask

    task automatic test_reset_conv;
        int seen_done;
        load(100, 27);
        do_start("pre_abort", 2'b00, 2'b00, '0);
        @(negedge clk);
        mode = 2'b00;
        btn  = 3'b100;
        @(negedge clk);
        btn  = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, ovf, rng, neg} !== 5'b0) begin
            errors++;
            $display("FAIL abort outs got=%b exp=00000",
                     {busy, done, ovf, rng, neg});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        m_op1     = 0;
        m_op2     = 0;
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort activity got=%0d exp=0", seen_done);
        end
        check_display("abort_disp", 0, 0, 0);
    endtask

    task automatic test_random;
        int a, b;
        logic [1:0] m;
        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            m = 2'($urandom_range(0, 3));
            load(a, b);
            do_start("random", m, 2'b00, '0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_simul_load();
        test_busy_load();
        test_reset_conv();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
